// File: rtl/ice51_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ice51_boot_ctrl
//  Description : Boot sequencer for ice51_top. Holds the CPU in reset while
//                MEM_SIZE bytes arrive from UART RX and are written into code
//                memory. It then returns an 8-bit additive checksum over
//                UART TX, waits RUN_DLY cycles and releases the CPU. In RUN
//                the code-memory address port follows the CPU fetch address.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   i_clk        in   1       clock
//   i_nrst       in   1       reset, asynchronous, active-high
//   i_rx_valid   in   1       one-cycle strobe, i_rx_data holds a byte
//   i_rx_data    in   8       received UART byte
//   i_tx_ready   in   1       UART TX can accept a byte this cycle
//   o_tx_valid   out  1       checksum byte offered to UART TX
//   o_tx_data    out  8       checksum byte
//   i_cpu_addr   in   ADDR_W  CPU code fetch address
//   o_mem_we     out  1       code memory write enable
//   o_mem_addr   out  ADDR_W  code memory address
//   o_mem_wdata  out  8       code memory write data
//   o_cpu_rst    out  1       CPU reset, active-high
//   o_done       out  1       high while in RUN
// ============================================================================
module ice51_boot_ctrl #(
    parameter int MEM_SIZE    = 512,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 65536,
    parameter int RUN_DLY     = 4,
    parameter int PRELOAD     = 0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_ready,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_rst,
    output logic              o_done
);

    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int HOLD_W  = $clog2(RUN_DLY + 1) + 1;

    localparam logic [ADDR_W-1:0]  LAST_PTR   = ADDR_W'(MEM_SIZE - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RUN_DLY);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          sum;
    logic [TIMER_W-1:0]  timer;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [7:0]          sum_next;

    assign sum_next = sum + i_rx_data;

    always_ff @(posedge i_clk or posedge i_nrst) begin
        if (i_nrst) begin
            state       <= (PRELOAD != 0) ? ST_HOLD : ST_LOAD;
            ptr         <= '0;
            wr_addr     <= '0;
            sum         <= '0;
            timer       <= '0;
            hold_cnt    <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= '0;
            o_cpu_rst   <= 1'b1;
            o_done      <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (i_rx_valid) begin
                        // A byte always wins over timeout expiry in the same cycle.
                        o_mem_we    <= 1'b1;
                        wr_addr     <= ptr;
                        o_mem_wdata <= i_rx_data;
                        sum         <= sum_next;
                        timer       <= '0;
                        if (ptr == LAST_PTR) begin
                            // Pointer parks on the last address so it never wraps.
                            state      <= ST_ACK;
                            o_tx_valid <= 1'b1;
                            o_tx_data  <= sum_next;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else if (ptr != '0) begin
                        if (timer == TIMER_LAST) begin
                            ptr   <= '0;
                            sum   <= '0;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        state      <= ST_HOLD;
                        // The transfer cycle itself is the first hold cycle.
                        hold_cnt   <= HOLD_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_RUN;
                        o_cpu_rst <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // The CPU fetch path gets the memory port with no added latency.
    assign o_mem_addr = (state == ST_RUN) ? i_cpu_addr : wr_addr;

endmodule
`default_nettype wire
